// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo write-port arbiter: FSM state encoding and
// a ceil-log2 helper used to size the grant index.
package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int bits;
        bits = 32'sd0;
        while ((32'sd1 <<< bits) < value) begin
            bits = bits + 32'sd1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/fifo-side bundle of the write arbiter. master = arbiter view,
// slave = the requesters plus fifo that surround it.
interface fifo_wr_arbiter_if
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int n_req   = 4,
    parameter int data_wd = 32,
    parameter int sel_wd  = clog2(n_req)
);
    logic [n_req-1:0]         req;
    logic [n_req-1:0]         last;
    logic [n_req*data_wd-1:0] req_data;
    logic [n_req-1:0]         ack;
    logic                     fifo_full;
    logic                     fifo_wr;
    logic [data_wd-1:0]       fifo_wr_data;
    logic                     grant_vld;
    logic [sel_wd-1:0]        grant_id;

    modport master (
        input  req, last, req_data, fifo_full,
        output ack, fifo_wr, fifo_wr_data, grant_vld, grant_id
    );

    modport slave (
        output req, last, req_data, fifo_full,
        input  ack, fifo_wr, fifo_wr_data, grant_vld, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request after rr_ptr,
// wrapping modulo n_req.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int n_req  = 4,
    parameter int sel_wd = clog2(n_req)
) (
    input  logic [n_req-1:0]  req,
    input  logic [sel_wd-1:0] rr_ptr,
    output logic [sel_wd-1:0] winner,
    output logic              any_req
);

    assign any_req = |req;

    // Walk offsets 1..n_req from the pointer; the first hit wins
    always_comb begin
        logic [sel_wd:0]   sum_v;
        logic [sel_wd-1:0] idx_v;
        logic              found_v;
        winner  = '0;
        found_v = 1'b0;
        sum_v   = '0;
        idx_v   = '0;
        for (int k = 1; k <= n_req; k++) begin
            sum_v = {1'b0, rr_ptr} + (sel_wd+1)'(k);
            if (sum_v >= (sel_wd+1)'(n_req)) begin
                idx_v = sel_wd'(sum_v - (sel_wd+1)'(n_req));
            end else begin
                idx_v = sel_wd'(sum_v);
            end
            if (!found_v && req[idx_v]) begin
                winner  = idx_v;
                found_v = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between n_req requesters,
// with bursts capped at max_burst words and fifo_full as backpressure.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int n_req     = 4,
    parameter int sel_wd    = clog2(n_req),
    parameter int data_wd   = 32,
    parameter int max_burst = 8,
    parameter int cnt_wd    = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.master  bus
);

    state_t             state_r, state_s;
    logic [sel_wd-1:0]  grant_id_r, grant_id_s;
    logic [sel_wd-1:0]  rr_ptr_r, rr_ptr_s;
    logic [cnt_wd-1:0]  beat_cnt_r, beat_cnt_s;
    logic [sel_wd-1:0]  winner_s;
    logic               any_req_s;
    logic               req_sel_s;
    logic               last_sel_s;
    logic               wr_s;
    logic [n_req-1:0]   ack_s;
    logic [data_wd-1:0] data_s;

    fifo_wr_arbiter_rr_pick #(
        .n_req  (n_req),
        .sel_wd (sel_wd)
    ) u_rr_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    assign req_sel_s  = bus.req[grant_id_r];
    assign last_sel_s = bus.last[grant_id_r];

    // State, grant, pointer and beat registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            grant_id_r <= '0;
            rr_ptr_r   <= sel_wd'(n_req - 1);
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            grant_id_r <= grant_id_s;
            rr_ptr_r   <= rr_ptr_s;
            beat_cnt_r <= beat_cnt_s;
        end
    end

    // Next-state and write strobe; the write is masked during reset so it
    // drops in the very cycle reset is asserted
    always_comb begin
        state_s    = state_r;
        grant_id_s = grant_id_r;
        rr_ptr_s   = rr_ptr_r;
        beat_cnt_s = beat_cnt_r;
        wr_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s    = GRANT;
                    grant_id_s = winner_s;
                    rr_ptr_s   = winner_s;
                    beat_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                wr_s = req_sel_s && !bus.fifo_full && rst;
                if (!req_sel_s) begin
                    state_s = IDLE;
                end else if (wr_s) begin
                    beat_cnt_s = beat_cnt_r + cnt_wd'(1);
                    if (last_sel_s || (beat_cnt_r == cnt_wd'(max_burst - 1))) begin
                        state_s = IDLE;
                    end else begin
                        state_s = GRANT;
                    end
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // One-hot acknowledge and grantee data mux
    always_comb begin
        ack_s  = '0;
        data_s = '0;
        for (int i = 0; i < n_req; i++) begin
            if (grant_id_r == sel_wd'(i)) begin
                ack_s[i] = wr_s;
                data_s   = bus.req_data[i*data_wd +: data_wd];
            end else begin
                ack_s[i] = 1'b0;
            end
        end
    end

    assign bus.grant_vld    = (state_r == GRANT);
    assign bus.grant_id     = grant_id_r;
    assign bus.fifo_wr      = wr_s;
    assign bus.ack          = ack_s;
    assign bus.fifo_wr_data = data_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, all compared each cycle against a behavioural reference model.
module tb_fifo_wr_arbiter;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXB = 8;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.n_req(N), .data_wd(DW), .sel_wd(2)) bus ();

    fifo_wr_arbiter #(
        .n_req(N), .sel_wd(2), .data_wd(DW), .max_burst(MAXB), .cnt_wd(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // reference model: who holds the grant, who was granted last, beats taken
    bit  m_grant = 1'b0;
    int  m_gid   = 0;
    int  m_ptr   = N - 1;
    int  m_beats = 0;
    logic [N-1:0] ack_prev = '0;

    // observations for the directed literal checks
    int   wr_count = 0;
    int   grant_log[$];
    logic [DW-1:0] fifo_q[$];
    bit   prev_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit found;
        int idx;
        if (!rst) begin
            m_grant = 1'b0; m_gid = 0; m_ptr = N - 1; m_beats = 0;
        end else if (!m_grant) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && bus.req[idx]) begin
                    found = 1'b1; m_grant = 1'b1; m_gid = idx; m_ptr = idx; m_beats = 0;
                end
            end
        end else if (!bus.req[m_gid]) begin
            m_grant = 1'b0;
        end else if (!bus.fifo_full) begin
            m_beats++;
            if (bus.last[m_gid] || m_beats == MAXB) m_grant = 1'b0;
        end
    endtask

    // Compare process: check DUT outputs mid-cycle, then advance the model
    initial begin
        bit exp_wr;
        logic [N-1:0] exp_ack;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_wr  = m_grant && rst && bus.req[m_gid] && !bus.fifo_full;
                exp_ack = exp_wr ? (4'b0001 << m_gid) : 4'b0000;
                chk("grant_vld", 32'(bus.grant_vld), 32'(m_grant));
                chk("fifo_wr",   32'(bus.fifo_wr),   32'(exp_wr));
                chk("ack",       32'(bus.ack),       32'(exp_ack));
                if (m_grant) chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
                if (exp_wr) chk("fifo_wr_data", bus.fifo_wr_data, bus.req_data[m_gid*DW +: DW]);
                if (bus.fifo_wr === 1'b1) begin
                    wr_count++;
                    fifo_q.push_back(bus.fifo_wr_data);
                end
                if (bus.grant_vld === 1'b1 && !prev_vld) grant_log.push_back(int'(bus.grant_id));
                prev_vld = (bus.grant_vld === 1'b1);
                ack_prev = exp_ack;
                model_step();
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        wr_count = 0;
        grant_log.delete();
        fifo_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        bus.req = '0; bus.last = '0; bus.fifo_full = 1'b0;
        step(2);
        rst = 1'b1;
        clear_obs();
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        bus.req_data[i*DW +: DW] = d;
    endtask

    initial begin
        int exp_rr[6];
        exp_rr = '{0, 1, 2, 3, 0, 1};
        rst = 1'b0;
        bus.req = '0; bus.last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        reset_dut();

        // reset state
        chk("rst_grant_vld", 32'(bus.grant_vld), 32'd0);
        chk("rst_ack",       32'(bus.ack),       32'd0);
        chk("rst_fifo_wr",   32'(bus.fifo_wr),   32'd0);
        chk("rst_grant_id",  32'(bus.grant_id),  32'd0);

        // single requester, 3-word packet
        bus.req = 4'b0001; set_data(0, 32'hA0); step(2);
        set_data(0, 32'hA1); step(1);
        set_data(0, 32'hA2); bus.last = 4'b0001; step(1);
        bus.req = 4'b0000; bus.last = 4'b0000; step(2);
        chk("single_count", 32'(wr_count), 32'd3);
        chk("single_w0", (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD, 32'hA0);
        chk("single_w1", (fifo_q.size() > 1) ? fifo_q[1] : 32'hDEAD, 32'hA1);
        chk("single_w2", (fifo_q.size() > 2) ? fifo_q[2] : 32'hDEAD, 32'hA2);

        // round robin with single-word packets
        reset_dut();
        for (int i = 0; i < N; i++) set_data(i, 32'h100 + 32'(i));
        bus.req = 4'b1111; bus.last = 4'b1111; step(12);
        bus.req = 4'b0000; bus.last = 4'b0000;
        chk("rr_grants", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("rr_order", (grant_log.size() > i) ? 32'(grant_log[i]) : 32'hFF, 32'(exp_rr[i]));
        chk("rr_count", 32'(wr_count), 32'd6);

        // burst cap, then another requester wins over the capped one
        reset_dut();
        set_data(2, 32'h222); set_data(0, 32'h333);
        bus.req = 4'b0100; step(9);
        bus.req = 4'b0101; step(1);
        chk("cap_count", 32'(wr_count), 32'd8);
        step(1);
        chk("cap_next", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFF, 32'd0);
        bus.req = 4'b0000;

        // backpressure for 5 cycles mid-burst
        reset_dut();
        set_data(1, 32'h111);
        bus.req = 4'b0010; step(3);
        bus.fifo_full = 1'b1; step(5);
        chk("bp_stalled", 32'(wr_count), 32'd2);
        bus.fifo_full = 1'b0; step(7);
        chk("bp_count", 32'(wr_count), 32'd8);
        chk("bp_grants", 32'(grant_log.size()), 32'd1);
        bus.req = 4'b0000;

        // early release when the grantee drops its request
        reset_dut();
        set_data(3, 32'h444); set_data(0, 32'h555);
        bus.req = 4'b1000; step(1);
        bus.req = 4'b1001; step(2);
        bus.req = 4'b0001; step(3);
        chk("early_first", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFF, 32'd3);
        chk("early_second", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFF, 32'd0);
        chk("early_count", 32'(wr_count), 32'd3);
        bus.req = 4'b0000;

        // reset during the 4th word of a burst
        reset_dut();
        bus.req = 4'b0001; step(4);
        rst = 1'b0; step(1);
        chk("mid_rst_count", 32'(wr_count), 32'd3);
        rst = 1'b1; bus.req = 4'b0110; step(2);
        chk("mid_rst_grants", 32'(grant_log.size()), 32'd2);
        chk("mid_rst_regrant", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFF, 32'd1);
        chk("mid_rst_count2", 32'(wr_count), 32'd4);

        // random traffic honouring the hold-while-pending contract
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && !ack_prev[i] && rst) begin
                    if ($urandom_range(15) == 0) bus.req[i] = 1'b0;
                end else begin
                    bus.req[i]  = ($urandom_range(3) != 0);
                    bus.last[i] = ($urandom_range(3) == 0);
                    set_data(i, $urandom);
                end
            end
            bus.fifo_full = ($urandom_range(3) == 0);
            rst = ($urandom_range(199) != 0);
            step(1);
        end

        rst = 1'b1;
        step(1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
